kp_row_drive: RTL
=================

// Module: kp_row_drive
// PURPOSE
//  Row-drive side of the 4x4 keypad controller: strobes rows K_O active-low one at a time,
//  samples the active-low column inputs K_I, debounces, and emits a 4-bit key code with a
//  one-cycle valid strobe. Sits between keypad pads and the key consumer/display logic.
// PARAMETERS
//  SCAN_DIV        1000  clocks per row dwell (settle + sample); legal >= 2
//  DEBOUNCE_SCANS  4     consecutive matching dwell samples to accept press/release; >= 1
//  REPEAT_DWELLS   256   dwells between repeat strobes (used only with KP_ROW_DRIVE_REPEAT_EN)
// PORTS
//  CLK      in   1  system clock, rising edge
//  RST_N    in   1  asynchronous active-low reset
//  K_I      in   4  column inputs, active low, asynchronous pads (pulled up)
//  K_O      out  4  row drive, active low, exactly one bit low at all times after reset
//  KEY      out  4  key code {row[1:0], col[1:0]}; held until next accepted press
//  KEY_VLD  out  1  one-cycle strobe: KEY newly valid
//  KEY_DN   out  1  level: accepted key currently held
// BEHAVIOUR
//  Reset: K_O=4'b1110 (row 0), KEY=0, KEY_VLD=0, KEY_DN=0, FSM=SCAN, all counters 0.
//  K_I passes a 2-FF synchronizer (ks); all decisions use ks only.
//  Dwell counter counts 0..SCAN_DIV-1; "sample" = cycle where count==SCAN_DIV-1; then wraps.
//  Column priority (ks active low): ks[3]=0->col 3; else ks[2]=0->2; else ks[1]=0->1;
//   else ks[0]=0->0; ks==4'hF means no key.
//  FSM:
//   SCAN: at sample, no key -> row=row+1 (3 wraps to 0), K_O updates next cycle.
//         key -> capture cand={row,col}, match=1, row frozen, go DEBOUNCE (if DEBOUNCE_SCANS==1,
//         accept immediately as below).
//   DEBOUNCE: at each sample, code==cand -> match++; match==DEBOUNCE_SCANS -> KEY<=cand,
//         KEY_VLD=1 for exactly one cycle, KEY_DN=1, go HELD. Mismatch or no key -> match=0,
//         advance row, go SCAN; no strobe.
//   HELD: row frozen. At sample, no key -> rel++; else rel=0. rel==DEBOUNCE_SCANS -> KEY_DN=0,
//         advance row, go SCAN. A different key seen while held is ignored (KEY unchanged).
//  Latency: press stable from first sample to strobe = DEBOUNCE_SCANS-1 dwells after first
//   detecting sample, +1 clk register; sync adds 2 clk before detection.
//  Simultaneous keys in the driven row: highest column wins. Keys in other rows ignored until
//   that row is driven.
//  Only K_O changes at dwell boundaries; never two rows low, never all high.
//  Reset mid-operation: immediate return to reset values, pending debounce discarded, no strobe.
// CONFIGURATION
//  `define KP_ROW_DRIVE_REPEAT_EN: in HELD, repeat counter counts samples from acceptance;
//   every REPEAT_DWELLS samples while key still present, KEY_VLD pulses one cycle again
//   (KEY unchanged); counter clears on release or leaving HELD.
//  Without macro: exactly one KEY_VLD per accepted press; REPEAT_DWELLS unused, no repeat logic.
// TESTING  (bench params SCAN_DIV=4, DEBOUNCE_SCANS=2, REPEAT_DWELLS=3)
//  Reset, K_I=F for 40 clk -> K_O cycles 1110,1101,1011,0111,1110 every 4 clk; KEY_VLD never 1.
//  Press row 2/col 1 (K_I[1]=0 only while K_O=1011) held 30 clk -> one KEY_VLD, KEY=4'h9,
//   KEY_DN=1; release -> KEY_DN=0 after 2 no-key samples, scan resumes at row 3.
//  Bounce: K_I[0] low for 1 sample then high in row 0 -> no KEY_VLD, scan continues to row 1.
//  Row 1, K_I=4'b0110 (cols 3 and 0) -> KEY=4'h7 (col 3 wins).
//  Assert RST_N low during DEBOUNCE -> outputs reset values at once; no strobe after release.
//  With KP_ROW_DRIVE_REPEAT_EN: hold row 0/col 2 for 20 dwells -> KEY_VLD at accept then every
//   3 dwells, KEY=4'h2 throughout; without macro -> single strobe.

Source files
------------

// File: rtl/kp_row_drive_if.sv
// Keypad pad and key-event signal bundle for kp_row_drive.
// master: row-drive controller side; slave: pads/consumer side.
interface kp_row_drive_if;
  logic [3:0] k_i;
  logic [3:0] k_o;
  logic [3:0] key;
  logic       key_vld;
  logic       key_dn;

  modport master (
    input  k_i,
    output k_o,
    output key,
    output key_vld,
    output key_dn
  );

  modport slave (
    output k_i,
    input  k_o,
    input  key,
    input  key_vld,
    input  key_dn
  );
endinterface

// File: rtl/kp_row_drive.sv
// 4x4 keypad row-drive scanner: strobes rows active-low, debounces columns, emits key code + strobe.
// Optional auto-repeat while a key is held: define KP_ROW_DRIVE_REPEAT_EN.
module kp_row_drive #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_DWELLS  = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  kp_row_drive_if.master kp
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_SCANS + 1);
`ifdef KP_ROW_DRIVE_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_DWELLS + 1);
`endif

  if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || REPEAT_DWELLS < 1) begin : g_param_check
    $error("kp_row_drive: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  function automatic logic [3:0] row_drive(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       row_q, row_d;
  logic [3:0]       k_o_q, k_o_d;
  logic [3:0]       cand_q, cand_d;
  logic [DEB_W-1:0] match_q, match_d;
  logic [DEB_W-1:0] rel_q, rel_d;
  logic [3:0]       key_q, key_d;
  logic             key_vld_q, key_vld_d;
  logic             key_dn_q, key_dn_d;
`ifdef KP_ROW_DRIVE_REPEAT_EN
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  logic [3:0] sync1_q, ks_q;
  logic       sample_c;
  logic       hit_c;
  logic [1:0] col_c;
  logic [3:0] code_c;

  // Two-flop synchronizer on the asynchronous column pads (idle = pulled high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'hF;
      ks_q    <= 4'hF;
    end else begin
      sync1_q <= kp.k_i;
      ks_q    <= sync1_q;
    end
  end

  // Dwell counter: the last count of each dwell is the sample cycle
  assign sample_c = (cnt_q == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (sample_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Highest active-low column wins
  always_comb begin
    hit_c = 1'b1;
    col_c = 2'd0;
    if (!ks_q[3]) begin
      col_c = 2'd3;
    end else if (!ks_q[2]) begin
      col_c = 2'd2;
    end else if (!ks_q[1]) begin
      col_c = 2'd1;
    end else if (!ks_q[0]) begin
      col_c = 2'd0;
    end else begin
      hit_c = 1'b0;
    end
  end

  assign code_c = {row_q, col_c};

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    k_o_d     = k_o_q;
    cand_d    = cand_q;
    match_d   = match_q;
    rel_d     = rel_q;
    key_d     = key_q;
    key_vld_d = 1'b0;
    key_dn_d  = key_dn_q;
`ifdef KP_ROW_DRIVE_REPEAT_EN
    rep_d     = rep_q;
`endif

    unique case (state_q)
      ST_SCAN: begin
        if (sample_c) begin
          if (!hit_c) begin
            row_d = row_q + 2'd1;
            k_o_d = row_drive(row_q + 2'd1);
          end else begin
            cand_d  = code_c;
            match_d = DEB_W'(1);
            if (DEBOUNCE_SCANS == 1) begin
              key_d     = code_c;
              key_vld_d = 1'b1;
              key_dn_d  = 1'b1;
              rel_d     = '0;
`ifdef KP_ROW_DRIVE_REPEAT_EN
              rep_d     = '0;
`endif
              state_d   = ST_HELD;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end
        end
      end

      ST_DEBOUNCE: begin
        if (sample_c) begin
          if (hit_c && (code_c == cand_q)) begin
            if ((match_q + DEB_W'(1)) == DEB_W'(DEBOUNCE_SCANS)) begin
              key_d     = cand_q;
              key_vld_d = 1'b1;
              key_dn_d  = 1'b1;
              rel_d     = '0;
`ifdef KP_ROW_DRIVE_REPEAT_EN
              rep_d     = '0;
`endif
              state_d   = ST_HELD;
            end else begin
              match_d = match_q + DEB_W'(1);
            end
          end else begin
            match_d = '0;
            row_d   = row_q + 2'd1;
            k_o_d   = row_drive(row_q + 2'd1);
            state_d = ST_SCAN;
          end
        end
      end

      ST_HELD: begin
        if (sample_c) begin
          if (!hit_c) begin
`ifdef KP_ROW_DRIVE_REPEAT_EN
            rep_d = '0;
`endif
            if ((rel_q + DEB_W'(1)) == DEB_W'(DEBOUNCE_SCANS)) begin
              rel_d    = '0;
              match_d  = '0;
              key_dn_d = 1'b0;
              row_d    = row_q + 2'd1;
              k_o_d    = row_drive(row_q + 2'd1);
              state_d  = ST_SCAN;
            end else begin
              rel_d = rel_q + DEB_W'(1);
            end
          end else begin
            // Any key in the frozen row (even a different one) keeps the hold alive
            rel_d = '0;
`ifdef KP_ROW_DRIVE_REPEAT_EN
            if ((rep_q + REP_W'(1)) == REP_W'(REPEAT_DWELLS)) begin
              rep_d     = '0;
              key_vld_d = 1'b1;
            end else begin
              rep_d = rep_q + REP_W'(1);
            end
`endif
          end
        end
      end

      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SCAN;
      row_q     <= 2'd0;
      k_o_q     <= 4'b1110;
      cand_q    <= 4'h0;
      match_q   <= '0;
      rel_q     <= '0;
      key_q     <= 4'h0;
      key_vld_q <= 1'b0;
      key_dn_q  <= 1'b0;
`ifdef KP_ROW_DRIVE_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      k_o_q     <= k_o_d;
      cand_q    <= cand_d;
      match_q   <= match_d;
      rel_q     <= rel_d;
      key_q     <= key_d;
      key_vld_q <= key_vld_d;
      key_dn_q  <= key_dn_d;
`ifdef KP_ROW_DRIVE_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign kp.k_o     = k_o_q;
  assign kp.key     = key_q;
  assign kp.key_vld = key_vld_q;
  assign kp.key_dn  = key_dn_q;

endmodule
